// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read hits return data combinationally; read misses refill a 4-word line
// from the memory bus; every store is forwarded to memory one word at a time.
module dcache_wt #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int NUM_LINES  = 64
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  cpu_rd_i,
   input  logic                  cpu_wr_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
   input  logic [BE_WIDTH-1:0]   cpu_wr_be_i,
   output logic [DATA_WIDTH-1:0] cpu_rd_data_o,
   output logic                  cpu_waitrequest_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wr_data_o,
   output logic [BE_WIDTH-1:0]   mem_wr_be_o,
   input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
   input  logic                  mem_waitrequest_i
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int LB_W  = ADDR_WIDTH - 4;          // line base = address without word/byte offset
   localparam int TAG_W = ADDR_WIDTH - 4 - IDX_W;

   typedef enum logic {
      IDLE,
      REFILL
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            beat_q, beat_d;
   logic [LB_W-1:0]       base_q, base_d;
   logic [NUM_LINES-1:0]  valid_q, valid_d;

   // Tag and data storage are never reset; only the valid bits are.
   logic [TAG_W-1:0]      tag_q  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_q [NUM_LINES*4];

   // Request address decode
   logic [1:0]            cpu_off;
   logic [IDX_W-1:0]      cpu_idx;
   logic [TAG_W-1:0]      cpu_tag;
   logic [IDX_W+1:0]      cpu_word;
   logic                  cpu_hit;
   logic [DATA_WIDTH-1:0] hit_word;
   logic [DATA_WIDTH-1:0] merged_word;

   // Refill line decode
   logic [IDX_W-1:0]      base_idx;
   logic [TAG_W-1:0]      base_tag;

   // Single write port into the data array (store merge or refill beat)
   logic                  data_we;
   logic [IDX_W+1:0]      data_waddr;
   logic [DATA_WIDTH-1:0] data_wdata;
   logic                  tag_we;

   // Byte offset bits never influence a word-granular cache
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign cpu_off  = cpu_addr_i[3:2];
   assign cpu_idx  = cpu_addr_i[4 +: IDX_W];
   assign cpu_tag  = cpu_addr_i[ADDR_WIDTH-1 -: TAG_W];
   assign cpu_word = {cpu_idx, cpu_off};
   assign cpu_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   assign hit_word = data_q[cpu_word];

   assign base_idx = base_q[IDX_W-1:0];
   assign base_tag = base_q[LB_W-1 -: TAG_W];

   // Read data is simply the addressed word; only meaningful on a hit
   assign cpu_rd_data_o = hit_word;

   // Store merge: enabled byte lanes come from the store, the rest from the cached word
   generate
      for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_merge
         assign merged_word[8*gi +: 8] = cpu_wr_be_i[gi] ? cpu_wr_data_i[8*gi +: 8]
                                                         : hit_word[8*gi +: 8];
      end
   endgenerate

   // Next-state, memory bus and stall logic for IDLE/REFILL
   always_comb begin
      state_d           = state_q;
      beat_d            = beat_q;
      base_d            = base_q;
      valid_d           = valid_q;
      cpu_waitrequest_o = 1'b0;
      mem_rd_o          = 1'b0;
      mem_wr_o          = 1'b0;
      mem_addr_o        = '0;
      mem_wr_data_o     = cpu_wr_data_i;
      mem_wr_be_o       = cpu_wr_be_i;
      data_we           = 1'b0;
      data_waddr        = cpu_word;
      data_wdata        = merged_word;
      tag_we            = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_wr_i) begin
               // Write-through; a simultaneous read is ignored this cycle
               mem_wr_o          = 1'b1;
               mem_addr_o        = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
               cpu_waitrequest_o = mem_waitrequest_i;
               if (!mem_waitrequest_i && cpu_hit) begin
                  data_we = 1'b1;
               end
            end else if (cpu_rd_i && !cpu_hit) begin
               // Invalidate now so a half-filled line can never produce a hit
               cpu_waitrequest_o = 1'b1;
               base_d            = cpu_addr_i[ADDR_WIDTH-1:4];
               beat_d            = 2'd0;
               valid_d[cpu_idx]  = 1'b0;
               state_d           = REFILL;
            end
         end

         REFILL: begin
            mem_rd_o          = 1'b1;
            mem_addr_o        = {base_q, beat_q, 2'b00};
            cpu_waitrequest_o = 1'b1;
            if (!mem_waitrequest_i) begin
               data_we    = 1'b1;
               data_waddr = {base_idx, beat_q};
               data_wdata = mem_rd_data_i;
               beat_d     = beat_q + 2'd1;
               if (beat_q == 2'd3) begin
                  valid_d[base_idx] = 1'b1;
                  tag_we            = 1'b1;
                  state_d           = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Control state and valid bits, cleared by the asynchronous reset
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         beat_q  <= 2'd0;
         base_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         valid_q <= valid_d;
      end
   end

   // Tag and data arrays
   always_ff @(posedge clock_i) begin
      if (data_we) begin
         data_q[data_waddr] <= data_wdata;
      end
      if (tag_we) begin
         tag_q[base_idx] <= base_tag;
      end
   end

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: the driver predicts each response from a
// flat memory image plus a per-index tag table and queues it; a negedge
// monitor compares the DUT's bus and stall behaviour cycle by cycle.
module tb_dcache_wt;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wr_data = '0;
   logic [3:0]  cpu_wr_be = '0;
   logic [31:0] cpu_rd_data;
   logic        cpu_waitrequest;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_be;
   logic [31:0] mem_rd_data = '0;
   logic        mem_waitrequest = 1'b0;

   dcache_wt #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .BE_WIDTH  (4),
      .NUM_LINES (64)
   ) dut (
      .clock_i          (clock),
      .reset_n_i        (reset_n),
      .cpu_rd_i         (cpu_rd),
      .cpu_wr_i         (cpu_wr),
      .cpu_addr_i       (cpu_addr),
      .cpu_wr_data_i    (cpu_wr_data),
      .cpu_wr_be_i      (cpu_wr_be),
      .cpu_rd_data_o    (cpu_rd_data),
      .cpu_waitrequest_o(cpu_waitrequest),
      .mem_rd_o         (mem_rd),
      .mem_wr_o         (mem_wr),
      .mem_addr_o       (mem_addr),
      .mem_wr_data_o    (mem_wr_data),
      .mem_wr_be_o      (mem_wr_be),
      .mem_rd_data_i    (mem_rd_data),
      .mem_waitrequest_i(mem_waitrequest)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   // Memory seen by the DUT (word(a)=a until written) and the reference image
   logic [31:0] bus_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] bus_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return bus_mem.exists(w) ? bus_mem[w] : w;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return ref_mem.exists(w) ? ref_mem[w] : w;
   endfunction

   always @(mem_addr or mem_rd) mem_rd_data = bus_word(mem_addr);

   // Memory back-pressure: scripted burst first, otherwise random when enabled
   int mw_hold    = 0;
   bit rand_waits = 1'b0;
   always @(posedge clock) begin
      #2;
      if (mw_hold > 0) begin
         mem_waitrequest = 1'b1;
         mw_hold--;
      end else begin
         mem_waitrequest = rand_waits ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
   end

   // Reference cache directory: which tag each index holds
   bit          ref_valid [64];
   logic [21:0] ref_tag   [64];

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          hit;
      logic [31:0] rdata;
      int          exp_stall;   // -1 when the stall depends on random back-pressure
   } txn_t;

   txn_t sq[$];
   int   done_cnt = 0;
   int   mon_n    = 0;   // cycles elapsed in the current transaction
   int   mon_acc  = 0;   // refill beats accepted so far
   txn_t mon_t;
   bit   mon_done;

   // Monitor: compares DUT behaviour against the head of the scoreboard
   always @(negedge clock) begin
      if (!reset_n) begin
         sq.delete();
         mon_n   = 0;
         mon_acc = 0;
      end else begin
         chk("mem_rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
         if (sq.size() == 0) begin
            chk("idle_outputs", {29'd0, mem_rd, mem_wr, cpu_waitrequest}, 32'd0);
         end else begin
            mon_t    = sq[0];
            mon_done = 1'b0;
            if (mon_t.is_wr) begin
               chk("wr_waitrequest", 32'(cpu_waitrequest), 32'(mem_waitrequest));
               chk("wr_mem_wr", 32'(mem_wr), 32'd1);
               chk("wr_mem_rd", 32'(mem_rd), 32'd0);
               chk("wr_mem_addr", mem_addr, {mon_t.addr[31:2], 2'b00});
               chk("wr_mem_data", mem_wr_data, mon_t.wdata);
               chk("wr_mem_be", 32'(mem_wr_be), 32'(mon_t.be));
               if (!mem_waitrequest) begin
                  if (mem_wr)
                     bus_mem[{mem_addr[31:2], 2'b00}] = merge(bus_word(mem_addr), mem_wr_data, mem_wr_be);
                  mon_done = 1'b1;
               end
            end else if (mon_t.hit || mon_acc == 4) begin
               chk("rd_waitrequest_low", 32'(cpu_waitrequest), 32'd0);
               chk("rd_data", cpu_rd_data, mon_t.rdata);
               chk("rd_done_mem_rd", 32'(mem_rd), 32'd0);
               mon_done = 1'b1;
            end else if (mon_n == 0) begin
               chk("miss_waitrequest", 32'(cpu_waitrequest), 32'd1);
               chk("miss_detect_mem_rd", 32'(mem_rd), 32'd0);
            end else begin
               chk("refill_waitrequest", 32'(cpu_waitrequest), 32'd1);
               chk("refill_mem_rd", 32'(mem_rd), 32'd1);
               chk("refill_mem_wr", 32'(mem_wr), 32'd0);
               chk("refill_mem_addr", mem_addr, {mon_t.addr[31:4], 4'h0} + 32'(mon_acc * 4));
               if (!mem_waitrequest) mon_acc++;
            end
            if (mon_done) begin
               if (mon_t.exp_stall >= 0) chk("stall_cycles", 32'(mon_n), 32'(mon_t.exp_stall));
               void'(sq.pop_front());
               mon_n   = 0;
               mon_acc = 0;
               done_cnt++;
            end else begin
               mon_n++;
            end
         end
      end
   end

   // Predict the response, queue it and drive the request
   task automatic start_txn(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input int exp_stall);
      txn_t t;
      int   idx;
      logic [21:0] tg;
      idx         = int'(addr[9:4]);
      tg          = addr[31:10];
      t.is_wr     = is_wr;
      t.addr      = addr;
      t.wdata     = wdata;
      t.be        = be;
      t.exp_stall = exp_stall;
      t.hit       = ref_valid[idx] && (ref_tag[idx] == tg);
      if (is_wr) begin
         ref_mem[{addr[31:2], 2'b00}] = merge(ref_word(addr), wdata, be);
         t.rdata = '0;
      end else begin
         t.rdata        = ref_word(addr);
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
      end
      $display("txn %s addr=0x%08h wdata=0x%08h be=%b predicted_hit=%0d rdata=0x%08h",
               is_wr ? (also_rd ? "RW" : "WR") : "RD", addr, wdata, be, t.hit, t.rdata);
      sq.push_back(t);
      cpu_addr    = addr;
      cpu_wr_data = wdata;
      cpu_wr_be   = be;
      cpu_wr      = is_wr;
      cpu_rd      = !is_wr || also_rd;
   endtask

   task automatic finish_now();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   task automatic issue(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int exp_stall);
      int  target;
      bit  ok;
      target = done_cnt + 1;
      start_txn(is_wr, also_rd, addr, wdata, be, exp_stall);
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clock);
         #1;
         if (done_cnt == target) begin
            ok = 1'b1;
            break;
         end
      end
      cpu_rd = 1'b0;
      cpu_wr = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL txn_timeout: addr 0x%08h never completed, required completion within 300 cycles", addr);
         finish_now();
      end
   endtask

   initial begin
      bit ok;
      for (int i = 0; i < 64; i++) begin
         ref_valid[i] = 1'b0;
         ref_tag[i]   = '0;
      end

      // Reset state
      #1;
      chk("reset_outputs", {29'd0, mem_rd, mem_wr, cpu_waitrequest}, 32'd0);
      repeat (3) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Cold miss, then a hit in the same line
      issue(1'b0, 1'b0, 32'h0000_0104, '0, 4'h0, 5);
      issue(1'b0, 1'b0, 32'h0000_0108, '0, 4'h0, 0);
      // Store hit with two cycles of memory back-pressure, then read it back
      mw_hold = 2;
      issue(1'b1, 1'b0, 32'h0000_0104, 32'hAABB_CCDD, 4'b1000, 2);
      issue(1'b0, 1'b0, 32'h0000_0104, '0, 4'h0, 0);
      // Store miss does not allocate
      issue(1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'b1111, 0);
      issue(1'b0, 1'b0, 32'h0000_2000, '0, 4'h0, 5);
      // Conflict eviction on index 0x10
      issue(1'b0, 1'b0, 32'h0000_0104, '0, 4'h0, 0);
      issue(1'b0, 1'b0, 32'h0000_0504, '0, 4'h0, 5);
      issue(1'b0, 1'b0, 32'h0000_0104, '0, 4'h0, 5);
      // Zero byte enables still go to memory, cache keeps its word
      issue(1'b1, 1'b0, 32'h0000_0108, 32'hFFFF_FFFF, 4'b0000, 0);
      issue(1'b0, 1'b0, 32'h0000_0108, '0, 4'h0, 0);
      // Read and write together behave as a write
      issue(1'b1, 1'b1, 32'h0000_010C, 32'h0102_0304, 4'b1111, 0);
      issue(1'b0, 1'b0, 32'h0000_010C, '0, 4'h0, 0);

      // Reset in the middle of a refill, after two beats
      start_txn(1'b0, 1'b0, 32'h0000_3004, '0, 4'h0, 5);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         #1;
         if (mon_acc == 2) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_refill_beat2", 32'(ok), 32'd1);
      @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      chk("reset_drops_mem_rd", 32'(mem_rd), 32'd0);
      cpu_rd = 1'b0;
      for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock);
      #1;
      issue(1'b0, 1'b0, 32'h0000_3004, '0, 4'h0, 5);
      issue(1'b0, 1'b0, 32'h0000_3008, '0, 4'h0, 0);

      // Randomised traffic over a small address pool to mix hits, misses and evictions
      rand_waits = 1'b1;
      for (int n = 0; n < 200; n++) begin
         int          kind;
         logic [31:0] a;
         kind = int'($urandom_range(0, 3));
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         if (kind <= 1)
            issue(1'b0, 1'b0, a, '0, 4'h0, -1);
         else
            issue(1'b1, kind == 3, a, $urandom, 4'($urandom_range(0, 15)), -1);
      end
      rand_waits = 1'b0;
      repeat (3) @(posedge clock);
      finish_now();
   end

endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache that sits directly downstream of the pipeline memory stage. It serves the stage's cache_rd/cache_wr requests, returns read data combinationally on hits, and stalls the stage through a waitrequest handshake. On read misses it refills a 4-word line from the memory bus. Stores always go to memory, one word per store.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed at 32
- BE_WIDTH, DATA_WIDTH/8, byte enables per word
- NUM_LINES, 64, number of lines; must be a power of 2
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  reset; asynchronous and active-low
- cpu_rd  in  1  read request from the memory stage
- cpu_wr  in  1  write request from the memory stage
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- cpu_wr_data  in  DATA_WIDTH  store word, already byte-lane aligned
- cpu_wr_be  in  BE_WIDTH  byte enables; bit i covers data[8i+7:8i]; bit 3 is byte offset 0 (big-endian)
- cpu_rd_data  out  DATA_WIDTH  read word; valid when cpu_rd=1 and cpu_waitrequest=0
- cpu_waitrequest  out  1  combinational stall back to the memory stage
- mem_rd  out  1  memory word read request
- mem_wr  out  1  memory word write request
- mem_addr  out  ADDR_WIDTH  word-aligned memory address
- mem_wr_data  out  DATA_WIDTH  write data
- mem_wr_be  out  BE_WIDTH  write byte enables
- mem_rd_data  in  DATA_WIDTH  read data, valid in the accept cycle
- mem_waitrequest  in  1  memory not accepting; a request is accepted in any cycle where it is asserted and mem_waitrequest=0

## Operation
- Address split: offset [3:2] selects the word in the line; index [3+log2(NUM_LINES):4]; tag is the remaining upper bits.
- Storage: per line, one valid bit, one tag, and 4 data words. Everything is held in flops and reads asynchronously.
- FSM states: IDLE and REFILL. There is also a 2-bit beat counter.
- IDLE, cpu_rd hit (valid and tag match):
  - cpu_rd_data is the addressed word.
  - cpu_waitrequest=0 in the same cycle.
- IDLE, cpu_rd miss:
  - cpu_waitrequest=1.
  - Latch the line base address; beat=0; next state REFILL.
- REFILL:
  - mem_rd=1; mem_addr = line base + beat*4.
  - On each accepted beat, write mem_rd_data into data word[beat] and increment beat.
  - On the accept of beat 3, set valid, write the tag, and return to IDLE.
  - The valid bit is cleared on entry to REFILL, so a partially filled line never hits.
- IDLE, cpu_wr (write-through):
  - mem_wr=1 combinationally; mem_addr = cpu_addr with [1:0] forced to 0; mem_wr_data = cpu_wr_data; mem_wr_be = cpu_wr_be.
  - cpu_waitrequest = mem_waitrequest.
  - On accept, if the access hits, merge the enabled bytes into the cached word.
  - On a miss, the cache is unchanged.
- cpu_rd and cpu_wr both high: treated as a write; cpu_rd is ignored for that cycle.
- Upstream holds cpu_* stable while cpu_waitrequest=1. A refill always runs to completion once started.
- cpu_wr_be=0000 with cpu_wr=1: the write is still issued to memory; the cache is unchanged.
- No uncached region: the trickbox is decoded upstream, and its accesses never reach this block.

## Timing
- Reset (asynchronous, active-low):
  - State=IDLE, beat=0, all valid bits=0; tags and data are not reset.
  - mem_rd=0, mem_wr=0, cpu_waitrequest=0 while cpu_rd=cpu_wr=0.
  - cpu_rd_data and mem_wr_data are don't-care.
- Reset asserted mid-REFILL: mem_rd drops asynchronously, the partial line stays invalid, and no memory beat is counted.
- Read hit latency: 0 cycles (combinational, same cycle).
- Read miss, cpu_rd asserted in cycle 0 with mem_waitrequest=0 throughout:
  - Cycle 0: miss detected.
  - Cycles 1-4: REFILL beats.
  - Cycle 5: IDLE, hit, cpu_waitrequest=0.
  - Total: 5 stall cycles. Each mem_waitrequest=1 cycle during REFILL adds one cycle.
- Write: 0 extra cycles when mem_waitrequest=0; otherwise stalled 1:1 with mem_waitrequest.
- mem_rd and mem_wr are never asserted in the same cycle.
- In IDLE with no request, mem_rd=mem_wr=0.

## Test plan
- Reset, then cpu_rd at 0x00000104 with memory word(a)=a:
  - cpu_waitrequest is high for 5 cycles.
  - mem_addr sequences 0x100, 0x104, 0x108, 0x10C.
  - Then cpu_rd_data=0x00000104 with cpu_waitrequest low.
- Repeat the read of 0x00000108: hits in 0 cycles with data 0x00000108, and mem_rd stays 0.
- Write 0xAABBCCDD to 0x00000104 with be=1000 (hit), memory waitrequest high for 2 cycles:
  - cpu_waitrequest is high for 2 cycles.
  - Then the write is accepted.
  - A following read of 0x104 returns 0xAA000104 from cache.
- Write to miss address 0x00002000, be=1111: one mem_wr is issued, and a subsequent read of 0x2000 misses and refills.
- Read 0x00000104 then 0x00000504 (same index, different tag):
  - The second read evicts the first line.
  - A re-read of 0x104 misses again.
- Assert reset_n low at REFILL beat 2, release, and read the same address:
  - The access misses.
  - A full 4-beat refill restarts from beat 0.
